rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares one read port of the asynchronous word-addressable ROM between two
//  requesters: req 0 = instruction fetch, req 1 = data load.
//  - Round-robin arbitration with valid/ready request handshakes.
//  - Byte-address range and alignment checking.
//  - One registered response buffer per requester, held until consumed.
//  Sits between the core's fetch/load units and the ROM port.
// PARAMETERS
//  ADDR_WIDTH  DEFAULT_ROM_ADDR_WIDTH  ROM word-address bits
//  BASE_ADDR   32'h0000_0000           ROM byte base; must be aligned to 2**(ADDR_WIDTH+2)
// PORTS
//  clk          in   1           clock; all state updates on rising edge
//  rst          in   1           reset, synchronous, active-high
//  req_valid    in   2           [i] requester i presents a read
//  req_addr     in   2x32        [i] byte address for requester i
//  req_ready    out  2           [i] request i accepted this cycle
//  resp_valid   out  2           [i] response buffer i holds data
//  resp_data    out  2x32        [i] read word (rv32::word); 0 on error
//  resp_err     out  2           [i] request was misaligned or out of range
//  resp_ready   in   2           [i] requester i consumes its response
//  rom_rd_en    out  1           ROM read enable (combinational)
//  rom_addr     out  ADDR_WIDTH  ROM word address (combinational)
//  rom_rd_data  in   32          ROM read data (combinational return)
// BEHAVIOUR
//  - Reset: resp_valid=0, resp_data=0, resp_err=0, last_grant=1.
//    last_grant=1 means req 0 wins the first tie.
//    Reset overrides any in-flight handshake; buffered responses are dropped.
//  - Eligibility: elig[i] = req_valid[i] && (!resp_valid[i] || resp_ready[i]).
//    A buffer draining in the same cycle may accept a new request.
//  - Grant (combinational): if exactly one requester is eligible, grant it.
//    If both are eligible, grant ~last_grant.
//    req_ready = one-hot grant; at most one bit is set per cycle.
//  - last_grant <= granted index, updated only on a cycle with a grant.
//  - Address check for the granted request, with a = req_addr[g]:
//    ok = (a[1:0]==0) && (a[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2])
//  - ROM side: rom_rd_en = grant && ok.
//    rom_addr = a[ADDR_WIDTH+1:2] when granted, else 0.
//  - Response buffer g, next edge after the grant:
//    resp_valid[g]<=1; resp_data[g] <= ok ? rom_rd_data : 0; resp_err[g] <= !ok.
//  - Latency: accept in cycle N -> resp_valid in N+1. Throughput is 1 word/cycle total.
//  - Drain: resp_valid[i] && resp_ready[i] with no new grant to i -> resp_valid[i]<=0.
//    resp_data and resp_err keep their values.
//  - Back-pressure: resp_valid[i]=1 && !resp_ready[i] -> req_ready[i]=0.
//    The other requester may still use the port.
//  - Stability: the buffer is unchanged while resp_valid[i] && !resp_ready[i].
//  - req_addr is sampled only on the grant cycle; requesters hold it until req_ready.
//  - resp_ready while resp_valid=0 is ignored.
// TESTING
//  1. rom[3]=32'hDEADBEEF; req0 addr 0x0C for 1 cycle, resp_ready0=1
//     -> req_ready0=1, rom_addr=3; next cycle resp_valid0=1, data=DEADBEEF, err=0.
//  2. Both requesters valid every cycle after reset, resp_ready=2'b11
//     -> grants alternate 0,1,0,1; never both set in one cycle.
//  3. req1 addr 0x0000_0006 -> rom_rd_en=0; next cycle resp_valid1=1, err1=1, data1=0.
//     Same for an address at BASE_ADDR + 4*2**ADDR_WIDTH.
//  4. resp_ready0=0 with resp_valid0=1, req0 and req1 valid
//     -> only req1 granted each cycle; resp_data0 is stable.
//     Raise resp_ready0 -> req0 granted the same cycle.
//  5. Accept req0, assert rst on the next edge
//     -> resp_valid=00, resp_err=00, resp_data=0; first tie after reset goes to req0.
//  6. Full-depth sweep: req1 reads every word 0..DEPTH-1 back-to-back
//     -> data matches rom.hex; one response per cycle; no errors.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one asynchronous ROM read port between instruction
// fetch (req 0) and data load (req 1), with address checking and per-requester response buffers.
module rom_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  req_valid,
    input  logic [1:0][31:0]            req_addr,
    output logic [1:0]                  req_ready,
    output logic [1:0]                  resp_valid,
    output logic [1:0][31:0]            resp_data,
    output logic [1:0]                  resp_err,
    input  logic [1:0]                  resp_ready,
    output logic                        rom_rd_en,
    output logic [ADDR_WIDTH-1:0]       rom_addr,
    input  logic [31:0]                 rom_rd_data
);

    // Bits above the ROM window must match the base; masking avoids an empty slice
    // when the window reaches the top of the address space.
    localparam logic [31:0] HI_MASK = ~((32'd1 << (ADDR_WIDTH + 2)) - 32'd1);

    logic [1:0]  elig;
    logic [1:0]  grant;
    logic        gnt_any;
    logic        gnt_idx;
    logic        last_grant;
    logic [31:0] sel_addr;
    logic        addr_ok;

    always_comb begin
        elig    = req_valid & (~resp_valid | resp_ready);
        grant   = '0;
        gnt_idx = 1'b0;
        unique case (elig)
            2'b01: begin
                grant   = 2'b01;
                gnt_idx = 1'b0;
            end
            2'b10: begin
                grant   = 2'b10;
                gnt_idx = 1'b1;
            end
            2'b11: begin
                gnt_idx = ~last_grant;
                grant   = gnt_idx ? 2'b10 : 2'b01;
            end
            default: begin
                grant   = '0;
                gnt_idx = 1'b0;
            end
        endcase

        gnt_any   = |grant;
        sel_addr  = req_addr[gnt_idx];
        addr_ok   = (sel_addr[1:0] == 2'b00) && ((sel_addr & HI_MASK) == (BASE_ADDR & HI_MASK));
        rom_rd_en = gnt_any && addr_ok;
        rom_addr  = gnt_any ? sel_addr[ADDR_WIDTH+1:2] : '0;
    end

    assign req_ready = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= '0;
            last_grant <= 1'b1;
        end else begin
            if (gnt_any) begin
                last_grant <= gnt_idx;
            end
            for (int unsigned i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    resp_valid[i] <= 1'b1;
                    resp_data[i]  <= addr_ok ? rom_rd_data : '0;
                    resp_err[i]   <= ~addr_ok;
                end else if (resp_valid[i] && resp_ready[i]) begin
                    resp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: a small arbitration model predicts grants,
// expected responses are queued on grant and compared when the buffer loads.
module tb_rom_port_arbiter;

    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_valid = '0;
    logic [1:0][31:0]  req_addr = '0;
    logic [1:0]        req_ready;
    logic [1:0]        resp_valid;
    logic [1:0][31:0]  resp_data;
    logic [1:0]        resp_err;
    logic [1:0]        resp_ready = '0;
    logic              rom_rd_en;
    logic [AW-1:0]     rom_addr;
    logic [31:0]       rom_rd_data;

    logic [31:0] rom [0:DEPTH-1];

    typedef struct packed {
        logic        idx;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [1:0]  m_valid;
    logic        m_last;
    logic [31:0] held_data [2];
    logic        held_err  [2];

    int checks   = 0;
    int failures = 0;

    rom_port_arbiter #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .resp_ready  (resp_ready),
        .rom_rd_en   (rom_rd_en),
        .rom_addr    (rom_addr),
        .rom_rd_data (rom_rd_data)
    );

    always #5 clk = ~clk;

    assign rom_rd_data = rom[rom_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:AW+2] == BASE[31:AW+2]);
    endfunction

    // One clock cycle: drive, check combinational grant/ROM side, then check buffers after the edge.
    task automatic cycle(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [1:0] rr);
        logic [1:0]  elig;
        logic [1:0]  g;
        logic        gi;
        logic [31:0] a;
        logic        ok;
        logic [AW-1:0] wa;
        exp_t        e;
        req_valid   = v;
        req_addr[0] = a0;
        req_addr[1] = a1;
        resp_ready  = rr;
        #4;
        elig = v & (~m_valid | rr);
        g    = 2'b00;
        gi   = 1'b0;
        if (elig == 2'b01) begin g = 2'b01; gi = 1'b0; end
        else if (elig == 2'b10) begin g = 2'b10; gi = 1'b1; end
        else if (elig == 2'b11) begin gi = ~m_last; g = gi ? 2'b10 : 2'b01; end
        check("req_ready", {62'd0, req_ready}, {62'd0, g});
        if (g != 2'b00) begin
            a  = gi ? a1 : a0;
            ok = addr_ok(a);
            wa = a[AW+1:2];
            check("rom_rd_en", {63'd0, rom_rd_en}, {63'd0, ok});
            check("rom_addr", {{(64-AW){1'b0}}, rom_addr}, {{(64-AW){1'b0}}, wa});
            e.idx  = gi;
            e.err  = ~ok;
            e.data = ok ? rom[wa] : 32'd0;
            sbq.push_back(e);
        end else begin
            check("rom_rd_en_idle", {63'd0, rom_rd_en}, 64'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
                m_valid[i] = 1'b1;
                if (sbq.size() == 0) begin
                    check("sb_empty", 64'd0, 64'd1);
                end else begin
                    e = sbq.pop_front();
                    check("sb_idx", {63'd0, e.idx}, i[63:0]);
                    held_data[i] = e.data;
                    held_err[i]  = e.err;
                end
                check("resp_valid_load", {63'd0, resp_valid[i]}, 64'd1);
            end else if (m_valid[i] && rr[i]) begin
                m_valid[i] = 1'b0;
                check("resp_valid_drain", {63'd0, resp_valid[i]}, 64'd0);
            end else begin
                check("resp_valid_hold", {63'd0, resp_valid[i]}, {63'd0, m_valid[i]});
            end
            check("resp_data", {32'd0, resp_data[i]}, {32'd0, held_data[i]});
            check("resp_err", {63'd0, resp_err[i]}, {63'd0, held_err[i]});
        end
        if (g != 2'b00) m_last = gi;
    endtask

    // Reset edge, optionally with a request being accepted in the same cycle.
    task automatic do_reset(input logic [1:0] v);
        req_valid   = v;
        req_addr[0] = 32'h0000_000C;
        req_addr[1] = 32'h0000_0010;
        resp_ready  = 2'b11;
        rst         = 1'b1;
        #4;
        if (v == 2'b01) check("rst_cycle_grant", {62'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        check("rst_resp_valid", {62'd0, resp_valid}, 64'd0);
        check("rst_resp_err", {62'd0, resp_err}, 64'd0);
        check("rst_resp_data", {resp_data[1], resp_data[0]}, 64'd0);
        sbq.delete();
        m_valid = '0;
        m_last  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            held_data[i] = 32'd0;
            held_err[i]  = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'hA5C3_0000 ^ (i * 32'h0101_0107);
        rom[3] = 32'hDEAD_BEEF;

        @(posedge clk);
        #1;
        do_reset(2'b00);

        // Single fetch of word 3
        cycle(2'b01, 32'h0000_000C, 32'h0, 2'b11);
        cycle(2'b00, 32'h0, 32'h0, 2'b11);

        // Both always valid: alternating grants
        for (int k = 0; k < 6; k++)
            cycle(2'b11, k * 4, (k + 10) * 4, 2'b11);
        cycle(2'b00, 32'h0, 32'h0, 2'b11);

        // Misaligned and out-of-range loads
        cycle(2'b10, 32'h0, 32'h0000_0006, 2'b11);
        cycle(2'b10, 32'h0, BASE + 4 * DEPTH, 2'b11);
        cycle(2'b10, 32'h0, 32'h8000_0004, 2'b11);
        cycle(2'b01, BASE + 4 * DEPTH - 4, 32'h0, 2'b11);

        // Back-pressure on req 0 while req 1 keeps the port
        cycle(2'b01, 32'h0000_0014, 32'h0, 2'b11);
        for (int k = 0; k < 4; k++)
            cycle(2'b11, 32'h0000_0018, (k + 20) * 4, 2'b10);
        cycle(2'b11, 32'h0000_0018, 32'h0000_0040, 2'b11);
        cycle(2'b00, 32'h0, 32'h0, 2'b11);

        // Reset drops an in-flight accept; first tie then goes to req 0
        do_reset(2'b01);
        cycle(2'b11, 32'h0000_0008, 32'h0000_0020, 2'b11);
        cycle(2'b00, 32'h0, 32'h0, 2'b11);

        // Full-depth sweep on req 1
        for (int k = 0; k < DEPTH; k++)
            cycle(2'b10, 32'h0, BASE + k * 4, 2'b11);
        cycle(2'b00, 32'h0, 32'h0, 2'b11);

        // Randomised traffic with random back-pressure
        for (int k = 0; k < 300; k++) begin
            logic [31:0] ra0, ra1;
            ra0 = $urandom_range(0, 4 * DEPTH + 16);
            ra1 = $urandom_range(0, 4 * DEPTH + 16);
            if ($urandom_range(0, 3) != 0) ra0[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) ra1[1:0] = 2'b00;
            cycle(2'($urandom_range(0, 3)), ra0, ra1, 2'($urandom_range(0, 3)));
        end
        cycle(2'b00, 32'h0, 32'h0, 2'b11);
        check("sb_drained", {32'd0, sbq.size()}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
